match_ctrl: RTL and testbench
=============================

Name: match_ctrl

Overview:
Parametrised match/round controller. It generalises the two-player start/game-over logic to N players, best-of-K rounds, a pre-round countdown, a post-round hold and an optional pause. It sits between input/selection logic and the tank/bullet/collision/renderer blocks. It generates the game tick, per-round reset pulses, phase and score information consumed by game modules and the renderer.

Parameters:
N_PLAYERS, 2, number of players (2..8)
WIN_ROUNDS, 3, round wins needed to win the match (1..15)
TICK_DIV, 3333334, clk cycles per game tick (>=2)
COUNTDOWN_TICKS, 90, game ticks spent in COUNTDOWN before PLAY (1..255)
END_TICKS, 60, game ticks held in ROUND_END (1..255)
Derived: SW = $clog2(WIN_ROUNDS+1); PW = max(1,$clog2(N_PLAYERS)).

Ports:
clk  in  1  system clock
rstn  in  1  reset, synchronous, active-low
game_reset  in  1  soft reset, synchronous active-high, same effect as rstn
ready  in  N_PLAYERS  per-player ready level
alive  in  N_PLAYERS  per-player alive level from tank blocks
pause_req  in  1  single-cycle pause toggle request
game_tick  out  1  1-cycle pulse every TICK_DIV clks, free-running
play_tick  out  1  game_tick gated by play_en
play_en  out  1  high only in PLAY
round_reset  out  1  1-cycle pulse resetting tanks/bullets for a new round
phase  out  3  0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 ROUND_END, 4 MATCH_OVER, 5 PAUSED
countdown  out  8  remaining countdown ticks (0 outside COUNTDOWN)
round_num  out  8  rounds completed, saturates at 255
scores  out  N_PLAYERS*SW  packed round wins, player i at [i*SW +: SW]
round_winner  out  PW  winner of last round
round_draw  out  1  last round ended with zero players alive
match_over  out  1  high in MATCH_OVER
match_winner  out  PW  valid when match_over

Behaviour:
- Reset (rstn low or game_reset high, sampled on clk):
  - tick counter=0; phase=IDLE.
  - All outputs 0: scores, round_num, countdown, round_winner, round_draw, match_over, match_winner, round_reset, play_en, game_tick.
- Tick counter counts 0..TICK_DIV-1 and wraps. game_tick is registered high for the one cycle following the cycle in which the counter equals TICK_DIV-1. First pulse occurs TICK_DIV cycles after reset release. Tick counter runs in every phase.
- IDLE: when ready is all-ones for one clk, next cycle:
  - round_reset=1 for one cycle;
  - phase=COUNTDOWN;
  - countdown=COUNTDOWN_TICKS.
- COUNTDOWN:
  - Each game_tick decrements countdown.
  - On the tick where countdown is 1 it becomes 0 and phase=PLAY; play_en=1 the same cycle the phase changes.
  - alive is ignored in this phase.
- PLAY: evaluated every clk. Let cnt = popcount(alive).
  - cnt==1: winner index = position of the set bit; scores[winner] += 1; round_winner=winner; round_draw=0; round_num += 1; phase=ROUND_END; end-tick counter=END_TICKS.
  - cnt==0: round_draw=1; no score change; round_winner unchanged; round_num += 1; phase=ROUND_END.
  - cnt>=2: stay in PLAY.
- ROUND_END:
  - play_en=0.
  - Each game_tick decrements the end-tick counter.
  - When it expires: if any score == WIN_ROUNDS, phase=MATCH_OVER, match_over=1, match_winner=that player. Only the last round's winner can reach WIN_ROUNDS, so the result is unambiguous.
  - Otherwise: round_reset pulse, phase=COUNTDOWN, countdown reloaded.
- MATCH_OVER: terminal. Exits only via rstn or game_reset. ready is ignored.
- Scores never exceed WIN_ROUNDS; the increment uses SW-bit arithmetic.
- play_tick = game_tick & play_en, combinational from registered signals.
- Mid-operation soft reset takes priority over every transition in the same cycle.
- ready dropping during COUNTDOWN/PLAY has no effect.

Optional Feature:
MATCH_CTRL_PAUSE_EN.
- Defined:
  - pause_req in PLAY enters PAUSED: play_en=0, alive ignored, scores frozen.
  - pause_req in PAUSED returns to PLAY next cycle.
  - pause_req in any other phase is ignored.
  - game_tick keeps running in PAUSED.
- Undefined: pause_req is ignored and phase 5 never occurs.

Test Plan:
All scenarios use N_PLAYERS=2, WIN_ROUNDS=2, TICK_DIV=4, COUNTDOWN_TICKS=3, END_TICKS=2.
1. Release reset, hold inputs 0 -> game_tick pulses every 4 clks; phase=0; all outputs 0.
2. ready=2'b11 -> one round_reset pulse; phase=1, countdown 3,2,1,0 on successive ticks; then phase=2, play_en=1, play_tick pulses every 4 clks.
3. In PLAY drive alive=2'b10 -> next cycle scores={1,0} (p1 field=1), round_winner=1, round_num=1, phase=3. After 2 ticks: round_reset pulse, phase=1.
4. Second round alive=2'b00 -> round_draw=1, scores unchanged, round_num=2. Third round alive=2'b10 -> p1 score=2, then after END_TICKS phase=4, match_over=1, match_winner=1. Later ready toggles -> no change.
5. game_reset asserted in PLAY while alive=2'b01 in the same cycle -> no score change; next cycle phase=0 and all outputs 0.
6. (MATCH_CTRL_PAUSE_EN) pause_req in PLAY -> phase=5, play_tick silent while game_tick continues. alive=2'b01 during pause -> ignored. Second pause_req -> phase=2, and the still-held alive=2'b01 scores player 0 next cycle.

Source files
------------

// File: rtl/match_ctrl.sv
// Match/round controller for N-player best-of rounds: free-running game tick,
// countdown before each round, round result scoring, post-round hold and
// match-over detection.
// Optional feature macro: MATCH_CTRL_PAUSE_EN adds a PAUSED phase (phase 5)
// toggled by pause_req while in PLAY. Without it pause_req is ignored.
module match_ctrl #(
    parameter int N_PLAYERS       = 2,
    parameter int WIN_ROUNDS      = 3,
    parameter int TICK_DIV        = 3333334,
    parameter int COUNTDOWN_TICKS = 90,
    parameter int END_TICKS       = 60,
    localparam int SW             = $clog2(WIN_ROUNDS + 1),
    localparam int PW             = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1,
    localparam int TW             = $clog2(TICK_DIV)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    game_reset,
    input  logic [N_PLAYERS-1:0]    ready,
    input  logic [N_PLAYERS-1:0]    alive,
    input  logic                    pause_req,
    output logic                    game_tick,
    output logic                    play_tick,
    output logic                    play_en,
    output logic                    round_reset,
    output logic [2:0]              phase,
    output logic [7:0]              countdown,
    output logic [7:0]              round_num,
    output logic [N_PLAYERS*SW-1:0] scores,
    output logic [PW-1:0]           round_winner,
    output logic                    round_draw,
    output logic                    match_over,
    output logic [PW-1:0]           match_winner
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COUNTDOWN  = 3'd1,
        PLAY       = 3'd2,
        ROUND_END  = 3'd3,
        MATCH_OVER = 3'd4,
        PAUSED     = 3'd5
    } phase_t;

    phase_t                  state, state_next;
    logic [TW-1:0]           tick_cnt;
    logic [7:0]              end_cnt, end_next;
    logic [7:0]              countdown_next, round_num_next;
    logic [N_PLAYERS*SW-1:0] scores_next;
    logic [PW-1:0]           winner_next, match_winner_next;
    logic                    draw_next, match_over_next, round_reset_next, play_en_next;
    logic                    hard_reset;
    logic [3:0]              alive_cnt;
    logic [PW-1:0]           alive_idx;
    logic                    champ_found;
    logic [PW-1:0]           champ_idx;

    assign hard_reset = !rstn || game_reset;
    assign phase      = state;
    assign play_tick  = game_tick & play_en;

    // Free-running tick divider; game_tick is the registered wrap indication
    always_ff @(posedge clk) begin
        if (hard_reset) begin
            tick_cnt  <= '0;
            game_tick <= 1'b0;
        end else begin
            tick_cnt  <= (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + TW'(1);
            game_tick <= (tick_cnt == TW'(TICK_DIV - 1));
        end
    end

    // Count surviving players and find the (sole) survivor's index
    always_comb begin
        alive_cnt = '0;
        alive_idx = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (alive[i]) begin
                alive_cnt = alive_cnt + 4'd1;
                alive_idx = PW'(i);
            end
        end
    end

    // Detect a player that has reached the match-winning score
    always_comb begin
        champ_found = 1'b0;
        champ_idx   = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (scores[i*SW +: SW] == SW'(WIN_ROUNDS)) begin
                champ_found = 1'b1;
                champ_idx   = PW'(i);
            end
        end
    end

    // Phase sequencing and next values for all round/match bookkeeping
    always_comb begin
        state_next        = state;
        countdown_next    = countdown;
        end_next          = end_cnt;
        round_num_next    = round_num;
        scores_next       = scores;
        winner_next       = round_winner;
        draw_next         = round_draw;
        match_over_next   = match_over;
        match_winner_next = match_winner;
        round_reset_next  = 1'b0;
        play_en_next      = play_en;
        case (state)
            IDLE: begin
                if (&ready) begin
                    state_next       = COUNTDOWN;
                    countdown_next   = 8'(COUNTDOWN_TICKS);
                    round_reset_next = 1'b1;
                end
            end
            COUNTDOWN: begin
                if (game_tick) begin
                    countdown_next = countdown - 8'd1;
                    if (countdown == 8'd1) begin
                        state_next   = PLAY;
                        play_en_next = 1'b1;
                    end
                end
            end
            PLAY: begin
`ifdef MATCH_CTRL_PAUSE_EN
                if (pause_req) begin
                    state_next   = PAUSED;
                    play_en_next = 1'b0;
                end else
`endif
                if (alive_cnt <= 4'd1) begin
                    state_next     = ROUND_END;
                    play_en_next   = 1'b0;
                    end_next       = 8'(END_TICKS);
                    round_num_next = (round_num == 8'hFF) ? 8'hFF : round_num + 8'd1;
                    if (alive_cnt == 4'd1) begin
                        draw_next   = 1'b0;
                        winner_next = alive_idx;
                        for (int i = 0; i < N_PLAYERS; i++) begin
                            if (PW'(i) == alive_idx) begin
                                scores_next[i*SW +: SW] = scores[i*SW +: SW] + SW'(1);
                            end
                        end
                    end else begin
                        draw_next = 1'b1;
                    end
                end
            end
            ROUND_END: begin
                if (game_tick) begin
                    end_next = end_cnt - 8'd1;
                    if (end_cnt == 8'd1) begin
                        if (champ_found) begin
                            state_next        = MATCH_OVER;
                            match_over_next   = 1'b1;
                            match_winner_next = champ_idx;
                        end else begin
                            state_next       = COUNTDOWN;
                            countdown_next   = 8'(COUNTDOWN_TICKS);
                            round_reset_next = 1'b1;
                        end
                    end
                end
            end
            MATCH_OVER: begin
                state_next = MATCH_OVER;
            end
            PAUSED: begin
`ifdef MATCH_CTRL_PAUSE_EN
                if (pause_req) begin
                    state_next   = PLAY;
                    play_en_next = 1'b1;
                end
`else
                state_next = IDLE;
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and bookkeeping registers; either reset source clears everything
    always_ff @(posedge clk) begin
        if (hard_reset) begin
            state        <= IDLE;
            countdown    <= '0;
            end_cnt      <= '0;
            round_num    <= '0;
            scores       <= '0;
            round_winner <= '0;
            round_draw   <= 1'b0;
            match_over   <= 1'b0;
            match_winner <= '0;
            round_reset  <= 1'b0;
            play_en      <= 1'b0;
        end else begin
            state        <= state_next;
            countdown    <= countdown_next;
            end_cnt      <= end_next;
            round_num    <= round_num_next;
            scores       <= scores_next;
            round_winner <= winner_next;
            round_draw   <= draw_next;
            match_over   <= match_over_next;
            match_winner <= match_winner_next;
            round_reset  <= round_reset_next;
            play_en      <= play_en_next;
        end
    end

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl with N_PLAYERS=2, WIN_ROUNDS=2, TICK_DIV=4,
// COUNTDOWN_TICKS=3, END_TICKS=2. Pause scenario runs when MATCH_CTRL_PAUSE_EN
// is defined; otherwise pause_req is checked to be ignored.
module tb_match_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       game_reset = 1'b0;
    logic [1:0] ready = 2'b00;
    logic [1:0] alive = 2'b00;
    logic       pause_req = 1'b0;
    logic       game_tick, play_tick, play_en, round_reset;
    logic [2:0] phase;
    logic [7:0] countdown, round_num;
    logic [3:0] scores;
    logic [0:0] round_winner, match_winner;
    logic       round_draw, match_over;

    int errors = 0;
    int checks = 0;

    match_ctrl #(
        .N_PLAYERS(2), .WIN_ROUNDS(2), .TICK_DIV(4),
        .COUNTDOWN_TICKS(3), .END_TICKS(2)
    ) dut (
        .clk(clk), .rstn(rstn), .game_reset(game_reset), .ready(ready),
        .alive(alive), .pause_req(pause_req), .game_tick(game_tick),
        .play_tick(play_tick), .play_en(play_en), .round_reset(round_reset),
        .phase(phase), .countdown(countdown), .round_num(round_num),
        .scores(scores), .round_winner(round_winner), .round_draw(round_draw),
        .match_over(match_over), .match_winner(match_winner)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitTick();
        int n = 0;
        while (!game_tick && n < 20) begin
            step(1);
            n++;
        end
        checkOutput("tick_wait", game_tick, 1);
    endtask

    task automatic consumeTick();
        waitTick();
        step(1);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_phase"}, phase, 0);
        checkOutput({tag, "_scores"}, scores, 0);
        checkOutput({tag, "_rnum"}, round_num, 0);
        checkOutput({tag, "_cd"}, countdown, 0);
        checkOutput({tag, "_misc"}, {round_winner, round_draw, match_over, match_winner,
                                     round_reset, play_en, game_tick, play_tick}, 0);
    endtask

    initial begin
        // Reset and idle tick cadence
        step(3);
        rstn = 1'b1;
        checkCleared("reset");
        step(3);
        checkOutput("tick_early", game_tick, 0);
        step(1);
        checkOutput("tick_first", game_tick, 1);
        checkOutput("idle_phase", phase, 0);
        step(1);
        checkOutput("tick_low", game_tick, 0);
        step(3);
        checkOutput("tick_second", game_tick, 1);

        // Start: round_reset pulse and countdown
        ready = 2'b11;
        step(1);
        checkOutput("start_rr", round_reset, 1);
        checkOutput("start_phase", phase, 1);
        checkOutput("start_cd", countdown, 3);
        step(1);
        checkOutput("rr_pulse_end", round_reset, 0);
        checkOutput("cd_hold", countdown, 3);
        consumeTick();
        checkOutput("cd2", countdown, 2);
        alive = 2'b11;
        ready = 2'b00;
        consumeTick();
        checkOutput("cd1", countdown, 1);
        checkOutput("cd1_phase", phase, 1);
        consumeTick();
        checkOutput("cd0", countdown, 0);
        checkOutput("play_phase", phase, 2);
        checkOutput("play_en", play_en, 1);
        checkOutput("play_tick_low", play_tick, 0);
        waitTick();
        checkOutput("play_tick1", play_tick, 1);
        step(1);
        checkOutput("play_tick_off", play_tick, 0);
        checkOutput("play_stay", phase, 2);
        waitTick();
        checkOutput("play_tick2", play_tick, 1);

        // Round 1: player 1 wins
        alive = 2'b10;
        step(1);
        alive = 2'b11;
        checkOutput("r1_scores", scores, 4'b0100);
        checkOutput("r1_winner", round_winner, 1);
        checkOutput("r1_rnum", round_num, 1);
        checkOutput("r1_phase", phase, 3);
        checkOutput("r1_play_en", play_en, 0);
        consumeTick();
        checkOutput("r1_hold", phase, 3);
        consumeTick();
        checkOutput("r1_next_phase", phase, 1);
        checkOutput("r1_next_rr", round_reset, 1);
        checkOutput("r1_next_cd", countdown, 3);

        // Round 2: draw
        repeat (3) consumeTick();
        checkOutput("r2_phase", phase, 2);
        alive = 2'b00;
        step(1);
        alive = 2'b11;
        checkOutput("r2_draw", round_draw, 1);
        checkOutput("r2_scores", scores, 4'b0100);
        checkOutput("r2_winner", round_winner, 1);
        checkOutput("r2_rnum", round_num, 2);
        repeat (2) consumeTick();
        checkOutput("r2_next_phase", phase, 1);
        repeat (3) consumeTick();

        // Round 3: player 1 wins the match
        alive = 2'b10;
        step(1);
        checkOutput("r3_scores", scores, 4'b1000);
        checkOutput("r3_draw", round_draw, 0);
        checkOutput("r3_rnum", round_num, 3);
        consumeTick();
        checkOutput("r3_hold", match_over, 0);
        consumeTick();
        checkOutput("mo_phase", phase, 4);
        checkOutput("mo_flag", match_over, 1);
        checkOutput("mo_winner", match_winner, 1);
        checkOutput("mo_rr", round_reset, 0);
        ready = 2'b11;
        pause_req = 1'b1;
        step(1);
        pause_req = 1'b0;
        ready = 2'b00;
        step(6);
        checkOutput("mo_terminal", phase, 4);
        checkOutput("mo_scores", scores, 4'b1000);

        // Soft reset out of MATCH_OVER, then soft reset wins over a result in PLAY
        ready = 2'b11;
        alive = 2'b11;
        game_reset = 1'b1;
        step(1);
        game_reset = 1'b0;
        checkCleared("gr_mo");
        step(1);
        checkOutput("gr_restart", phase, 1);
        ready = 2'b00;
        repeat (3) consumeTick();
        checkOutput("gr_play", phase, 2);
`ifndef MATCH_CTRL_PAUSE_EN
        pause_req = 1'b1;
        step(1);
        pause_req = 1'b0;
        checkOutput("pause_ignored", phase, 2);
        checkOutput("pause_ignored_en", play_en, 1);
`endif
        alive = 2'b01;
        game_reset = 1'b1;
        step(1);
        game_reset = 1'b0;
        alive = 2'b11;
        checkCleared("gr_play");

`ifdef MATCH_CTRL_PAUSE_EN
        // Pause freezes the round; resume lets the held alive pattern score
        ready = 2'b11;
        step(1);
        ready = 2'b00;
        repeat (3) consumeTick();
        checkOutput("p_play", phase, 2);
        pause_req = 1'b1;
        step(1);
        pause_req = 1'b0;
        checkOutput("p_phase", phase, 5);
        checkOutput("p_en", play_en, 0);
        alive = 2'b01;
        waitTick();
        checkOutput("p_tick_runs", game_tick, 1);
        checkOutput("p_play_tick", play_tick, 0);
        step(1);
        checkOutput("p_frozen", scores, 0);
        checkOutput("p_still", phase, 5);
        pause_req = 1'b1;
        step(1);
        pause_req = 1'b0;
        checkOutput("p_resume", phase, 2);
        checkOutput("p_resume_en", play_en, 1);
        step(1);
        checkOutput("p_score", scores, 4'b0001);
        checkOutput("p_winner", round_winner, 0);
        checkOutput("p_end", phase, 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
